// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data memory with req/rsp handshake, wait states, byte lanes and error detection
module dmem_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = 'h10010000,
  parameter int              LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // One past the last legal byte, kept one bit wider so the compare cannot overflow.
  localparam logic [XLEN:0] END_ADDR = {1'b0, BASE_ADDR} + (XLEN+1)'(4 * DEPTH_WORDS);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      cnt_q;

  // Request fields captured at accept; the live request inputs are ignored while busy.
  logic            lat_we;
  logic [1:0]      lat_size;
  logic            lat_unsigned;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // Last response, presented on the outputs between responses.
  logic [XLEN-1:0] hold_rdata;
  logic            hold_err;

  logic            accept;
  logic            in_range;
  logic            misalign;
  logic            acc_err;
  logic [XLEN-1:0] offset;
  logic [IW-1:0]   idx;
  logic [XLEN-1:0] rd_word;
  logic [4:0]      sh_byte;
  logic [4:0]      sh_half;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] acc_rdata;
  logic [XLEN-1:0] wr_mask;
  logic [XLEN-1:0] wr_data;
  logic            do_write;

  assign accept = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> WAIT (LATENCY cycles) -> RESP -> IDLE, WAIT skipped when LATENCY is 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE, response pulse in RESP, otherwise the held response.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = hold_rdata;
    rsp_err   = hold_err;
    if (rst) begin
      rsp_rdata = '0;
      rsp_err   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: req_ready = 1'b1;
        S_RESP: begin
          rsp_valid = 1'b1;
          rsp_rdata = acc_rdata;
          rsp_err   = acc_err;
        end
        default: ;
      endcase
    end
  end

  // Capture the request on accept and run the wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      lat_we       <= 1'b0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else if (accept) begin
      cnt_q        <= 4'(LATENCY);
      lat_we       <= req_we;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_addr     <= req_addr;
      lat_wdata    <= req_wdata;
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Address decode and error classification of the latched request.
  always_comb begin
    in_range = ({1'b0, lat_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, lat_addr} < END_ADDR);
    case (lat_size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = lat_addr[0];
      SZ_WORD: misalign = (lat_addr[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
    acc_err = misalign || !in_range;
    offset  = lat_addr - BASE_ADDR;
    idx     = IW'(offset >> 2);
  end

  // Load path: pick the addressed lane and extend it to XLEN.
  always_comb begin
    rd_word  = mem[idx];
    sh_byte  = {lat_addr[1:0], 3'b000};
    sh_half  = {lat_addr[1], 4'b0000};
    rd_shift = rd_word >> sh_byte;
    case (lat_size)
      SZ_BYTE: ld_data = {{(XLEN-8){~lat_unsigned & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: ld_data = {{(XLEN-16){~lat_unsigned & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_data = rd_word;
    endcase
    acc_rdata = (acc_err || lat_we) ? '0 : ld_data;
  end

  // Store path: position right-aligned store data on its lanes and build the byte mask.
  always_comb begin
    case (lat_size)
      SZ_BYTE: begin
        wr_mask = XLEN'(8'hFF) << sh_byte;
        wr_data = XLEN'(lat_wdata[7:0]) << sh_byte;
      end
      SZ_HALF: begin
        wr_mask = XLEN'(16'hFFFF) << sh_half;
        wr_data = XLEN'(lat_wdata[15:0]) << sh_half;
      end
      default: begin
        wr_mask = '1;
        wr_data = lat_wdata;
      end
    endcase
    do_write = (state_q == S_RESP) && lat_we && !acc_err;
  end

  // Memory array: cleared on reset, read-modify-write of the addressed lanes at the RESP edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[idx] <= (rd_word & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // Response hold registers, updated whenever a response is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_rdata <= '0;
      hold_err   <= 1'b0;
    end else if (state_q == S_RESP) begin
      hold_rdata <= acc_rdata;
      hold_err   <= acc_err;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

  localparam logic [31:0] BASE = 32'h10010000;

  logic        clk;
  logic        rst;
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_we       [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [31:0] req_addr     [3];
  logic [31:0] req_wdata    [3];
  logic        rsp_valid    [3];
  logic [31:0] rsp_rdata    [3];
  logic        rsp_err      [3];

  int checks = 0;
  int errors = 0;

  // Instance 0: LATENCY=1, full depth. Instances 1/2: LATENCY=0 and 3 for timing.
  dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(16), .BASE_ADDR(BASE), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(16), .BASE_ADDR(BASE), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
    .req_size(req_size[2]), .req_unsigned(req_unsigned[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request on instance k; returns response data/err and cycles from accept to rsp_valid (-1 on timeout).
  task automatic access(input int k, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid[k] = 1'b1; req_we[k] = we; req_size[k] = size;
    req_unsigned[k] = uns; req_addr[k] = addr; req_wdata[k] = wdata;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout inst=%0d: req_ready=%b want 1", k, req_ready[k]);
    end
    @(negedge clk);
    // Scramble live inputs while busy; only latched values may matter.
    req_valid[k] = 1'b0; req_we[k] = ~we; req_size[k] = 2'b11;
    req_unsigned[k] = ~uns; req_addr[k] = 32'hFFFFFFFF; req_wdata[k] = 32'hA5A5A5A5;
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    if (!rsp_valid[k]) lat = -1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lt;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low: got %b want 0", req_ready[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL reset_ready_high: got %b want 1", req_ready[0]);
    end
    checks++;
    if ({rsp_valid[0], rsp_err[0], rsp_rdata[0]} !== 34'd0) begin
      errors++; $display("FAIL reset_rsp: valid=%b err=%b rdata=%h want 0/0/0",
                         rsp_valid[0], rsp_err[0], rsp_rdata[0]);
    end
    access(0, 1'b0, 2'b10, 1'b0, BASE, 32'h0, rd, er, lt);
    checks++;
    if (lt !== 2) begin
      errors++; $display("FAIL reset_lw_latency: got %0d want 2", lt);
    end
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL reset_lw_data: rdata=%h err=%b want 00000000/0", rd, er);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lt;
    access(0, 1'b1, 2'b10, 1'b0, BASE + 32'h4, 32'hDEADBEEF, rd, er, lt);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL sw_rsp: rdata=%h err=%b want 00000000/0", rd, er);
    end
    access(0, 1'b1, 2'b00, 1'b0, BASE + 32'h5, 32'hABCDEF11, rd, er, lt);
    access(0, 1'b0, 2'b10, 1'b0, BASE + 32'h4, 32'h0, rd, er, lt);
    checks++;
    if (rd !== 32'hDEAD11EF || er !== 1'b0) begin
      errors++; $display("FAIL sb_merge: rdata=%h err=%b want DEAD11EF/0", rd, er);
    end
    access(0, 1'b1, 2'b01, 1'b0, BASE + 32'hA, 32'h12348001, rd, er, lt);
    access(0, 1'b0, 2'b10, 1'b0, BASE + 32'h8, 32'h0, rd, er, lt);
    checks++;
    if (rd !== 32'h80010000) begin
      errors++; $display("FAIL sh_upper: rdata=%h want 80010000", rd);
    end
  endtask

  task automatic test_extend();
    logic [31:0] rd; logic er; int lt;
    logic [1:0]  sz  [6];
    logic        un  [6];
    logic [31:0] ad  [6];
    logic [31:0] exp [6];
    sz[0] = 2'b00; un[0] = 1'b0; ad[0] = BASE + 32'h7; exp[0] = 32'hFFFFFFDE;
    sz[1] = 2'b00; un[1] = 1'b1; ad[1] = BASE + 32'h7; exp[1] = 32'h000000DE;
    sz[2] = 2'b01; un[2] = 1'b0; ad[2] = BASE + 32'h6; exp[2] = 32'hFFFFDEAD;
    sz[3] = 2'b01; un[3] = 1'b1; ad[3] = BASE + 32'h6; exp[3] = 32'h0000DEAD;
    sz[4] = 2'b00; un[4] = 1'b0; ad[4] = BASE + 32'h5; exp[4] = 32'h00000011;
    sz[5] = 2'b01; un[5] = 1'b0; ad[5] = BASE + 32'h4; exp[5] = 32'h000011EF;
    for (int i = 0; i < 6; i++) begin
      access(0, 1'b0, sz[i], un[i], ad[i], 32'h0, rd, er, lt);
      checks++;
      if (rd !== exp[i] || er !== 1'b0) begin
        errors++; $display("FAIL load_ext[%0d]: rdata=%h err=%b want %h/0", i, rd, er, exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lt;
    logic [1:0]  sz [5];
    logic [31:0] ad [5];
    sz[0] = 2'b10; ad[0] = BASE + 32'h2;
    sz[1] = 2'b01; ad[1] = BASE + 32'h1;
    sz[2] = 2'b11; ad[2] = BASE;
    sz[3] = 2'b10; ad[3] = 32'h1000FFFC;
    sz[4] = 2'b10; ad[4] = BASE + 32'd4096;
    for (int i = 0; i < 5; i++) begin
      access(0, 1'b0, sz[i], 1'b0, ad[i], 32'h0, rd, er, lt);
      checks++;
      if (rd !== 32'h0 || er !== 1'b1) begin
        errors++; $display("FAIL load_err[%0d]: rdata=%h err=%b want 00000000/1", i, rd, er);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_err[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL err_hold: err=%b valid=%b want 1/0", rsp_err[0], rsp_valid[0]);
    end
    access(0, 1'b1, 2'b10, 1'b0, BASE + 32'd4092, 32'h55AA55AA, rd, er, lt);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL last_word_sw: err=%b want 0", er);
    end
    access(0, 1'b1, 2'b10, 1'b0, 32'h1000FFFC, 32'hBAD0BAD0, rd, er, lt);
    access(0, 1'b1, 2'b10, 1'b0, BASE + 32'd4096, 32'hCAFEF00D, rd, er, lt);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL sw_oob: rdata=%h err=%b want 00000000/1", rd, er);
    end
    access(0, 1'b1, 2'b10, 1'b0, BASE + 32'h6, 32'h99999999, rd, er, lt);
    access(0, 1'b1, 2'b01, 1'b0, BASE + 32'h5, 32'h7777, rd, er, lt);
    access(0, 1'b0, 2'b10, 1'b0, BASE + 32'd4092, 32'h0, rd, er, lt);
    checks++;
    if (rd !== 32'h55AA55AA || er !== 1'b0) begin
      errors++; $display("FAIL last_word_kept: rdata=%h err=%b want 55AA55AA/0", rd, er);
    end
    access(0, 1'b0, 2'b10, 1'b0, BASE, 32'h0, rd, er, lt);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL word0_kept: rdata=%h want 00000000", rd);
    end
    access(0, 1'b0, 2'b10, 1'b0, BASE + 32'h4, 32'h0, rd, er, lt);
    checks++;
    if (rd !== 32'hDEAD11EF) begin
      errors++; $display("FAIL word1_kept: rdata=%h want DEAD11EF", rd);
    end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic er; int lt;
    int exp_lat [3];
    exp_lat[0] = 2; exp_lat[1] = 1; exp_lat[2] = 4;
    for (int k = 0; k < 3; k++) begin
      access(k, 1'b1, 2'b10, 1'b0, BASE + 32'h8, 32'h0BADF00D + k, rd, er, lt);
      checks++;
      if (lt !== exp_lat[k]) begin
        errors++; $display("FAIL latency inst=%0d: got %0d want %0d", k, lt, exp_lat[k]);
      end
      checks++;
      if (req_ready[k] !== 1'b0) begin
        errors++; $display("FAIL ready_in_rsp inst=%0d: got %b want 0", k, req_ready[k]);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
        errors++; $display("FAIL after_rsp inst=%0d: valid=%b ready=%b want 0/1",
                           k, rsp_valid[k], req_ready[k]);
      end
      access(k, 1'b0, 2'b10, 1'b0, BASE + 32'h8, 32'h0, rd, er, lt);
      checks++;
      if (rd !== 32'h0BADF00D + k) begin
        errors++; $display("FAIL lat_readback inst=%0d: rdata=%h want %h", k, rd, 32'h0BADF00D + k);
      end
    end
  endtask

  task automatic test_back_to_back(input int k, input int period);
    int last;
    int nrsp;
    int nready;
    int window;
    last = -1; nrsp = 0; nready = 0;
    window = 4 * period;
    @(negedge clk);
    req_valid[k] = 1'b1; req_we[k] = 1'b0; req_size[k] = 2'b10;
    req_unsigned[k] = 1'b0; req_addr[k] = BASE + 32'h8; req_wdata[k] = 32'h0;
    for (int c = 0; c < window; c++) begin
      @(negedge clk);
      if (req_ready[k]) nready++;
      if (rsp_valid[k]) begin
        if (last >= 0) begin
          checks++;
          if (c - last !== period) begin
            errors++; $display("FAIL b2b_gap inst=%0d: got %0d want %0d", k, c - last, period);
          end
        end
        last = c;
        nrsp++;
      end
    end
    req_valid[k] = 1'b0;
    checks++;
    if (nrsp !== 4) begin
      errors++; $display("FAIL b2b_count inst=%0d: got %0d want 4", k, nrsp);
    end
    checks++;
    if (nready !== 4) begin
      errors++; $display("FAIL b2b_ready inst=%0d: ready cycles %0d want 4", k, nready);
    end
    repeat (period + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lt;
    int seen;
    seen = 0;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'b10;
    req_unsigned[0] = 1'b0; req_addr[0] = BASE + 32'h20; req_wdata[0] = 32'h12345678;
    checks++;
    if (req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL mid_ready: got %b want 1", req_ready[0]);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    if (rsp_valid[0]) seen++;
    checks++;
    if (req_ready[0] !== 1'b0) begin
      errors++; $display("FAIL mid_ready_rst: got %b want 0", req_ready[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL mid_no_rsp: rsp_valid seen %0d times want 0", seen);
    end
    access(0, 1'b0, 2'b10, 1'b0, BASE + 32'h20, 32'h0, rd, er, lt);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL mid_no_write: rdata=%h err=%b want 00000000/0", rd, er);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 2'b10;
      req_unsigned[k] = 1'b0; req_addr[k] = BASE; req_wdata[k] = 32'h0;
    end
    test_reset();
    test_store_load();
    test_extend();
    test_errors();
    test_latency();
    test_back_to_back(0, 3);
    test_back_to_back(1, 2);
    test_back_to_back(2, 5);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
